// File: rtl/cc_branch_unit.sv
// LC-3 style NZP condition-code register and branch-enable logic, extended with a
// bounded LIFO that saves and restores CC across interrupt/trap nesting.
module cc_branch_unit #(
    parameter int             WIDTH    = 16,
    parameter int             DEPTH    = 4,
    parameter logic [2:0]     RESET_CC = 3'b010,
    localparam int            LW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus,
    input  logic             ld_cc,
    input  logic             ld_ben,
    input  logic [2:0]       ir_nzp,
    input  logic             cc_push,
    input  logic             cc_pop,
    input  logic             clr_err,
    output logic             n,
    output logic             z,
    output logic             p,
    output logic             ben,
    output logic [LW-1:0]    stk_level,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             stk_err
);

    function automatic logic [2:0] classify(input logic signed [WIDTH-1:0] v);
        if (v == '0)
            return 3'b010;
        else if (v < 0)
            return 3'b100;
        else
            return 3'b001;
    endfunction

    logic [2:0]    cc_p0;
    // Sized to the level counter's range so it can be indexed without width games.
    logic [2:0]    stack [2**LW];
    logic [LW-1:0] top_idx;
    logic          do_push;
    logic          do_pop;
    logic          err_set;
    logic [2:0]    cc_nxt;

    assign stk_empty = (stk_level == '0);
    assign stk_full  = (stk_level == LW'(DEPTH));
    assign top_idx   = stk_level - LW'(1);

    // A simultaneous push and pop leaves the stack alone and only raises the error.
    assign do_push = cc_push && !cc_pop && !stk_full;
    assign do_pop  = cc_pop && !cc_push && !stk_empty;
    assign err_set = (cc_push && cc_pop)
                   || (cc_push && !cc_pop && stk_full)
                   || (cc_pop && !cc_push && stk_empty);

    always_comb begin
        cc_nxt = cc_p0;
        if (do_pop)
            cc_nxt = stack[top_idx];
        else if (ld_cc)
            cc_nxt = classify(bus);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_p0     <= RESET_CC;
            ben       <= 1'b0;
            stk_level <= '0;
            stk_err   <= 1'b0;
        end else begin
            cc_p0 <= cc_nxt;
            if (ld_ben)
                ben <= |(ir_nzp & cc_p0);
            if (do_push)
                stk_level <= stk_level + LW'(1);
            else if (do_pop)
                stk_level <= top_idx;
            if (err_set)
                stk_err <= 1'b1;
            else if (clr_err)
                stk_err <= 1'b0;
        end
    end

    // Saved entries are plain data; reset only discards them by clearing the level.
    always_ff @(posedge clk) begin
        if (do_push)
            stack[stk_level] <= cc_p0;
    end

    assign {n, z, p} = cc_p0;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Scoreboard bench for cc_branch_unit: directed scenarios followed by random traffic,
// checked against a queue-based behavioural model.
module tb_cc_branch_unit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] bus = '0;
    logic             ld_cc = 1'b0;
    logic             ld_ben = 1'b0;
    logic [2:0]       ir_nzp = 3'b000;
    logic             cc_push = 1'b0;
    logic             cc_pop = 1'b0;
    logic             clr_err = 1'b0;
    logic             n, z, p, ben;
    logic [LW-1:0]    stk_level;
    logic             stk_empty, stk_full, stk_err;

    cc_branch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_CC(3'b010)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ld_cc(ld_cc), .ld_ben(ld_ben),
        .ir_nzp(ir_nzp), .cc_push(cc_push), .cc_pop(cc_pop), .clr_err(clr_err),
        .n(n), .z(z), .p(p), .ben(ben), .stk_level(stk_level),
        .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  cc;
        logic        ben;
        logic [31:0] level;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [2:0] m_cc;
    logic       m_ben;
    logic       m_err;
    logic [2:0] m_stk[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_class(input logic [WIDTH-1:0] v);
        if (v == 0) return 3'b010;
        if (v >= (1 << (WIDTH - 1))) return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_reset();
        m_cc  = 3'b010;
        m_ben = 1'b0;
        m_err = 1'b0;
        m_stk.delete();
    endtask

    // Apply one cycle of inputs and record what the DUT must show after the next edge.
    task automatic step(input logic [WIDTH-1:0] b, input logic lc, input logic lb,
                        input logic [2:0] ir, input logic pu, input logic po, input logic cl);
        logic [2:0] old_cc;
        logic       eset;
        exp_t       e;
        @(negedge clk);
        bus = b; ld_cc = lc; ld_ben = lb; ir_nzp = ir;
        cc_push = pu; cc_pop = po; clr_err = cl;
        old_cc = m_cc;
        eset   = 1'b0;
        if (lb) m_ben = |(ir & old_cc);
        if (pu && po) begin
            eset = 1'b1;
            if (lc) m_cc = ref_class(b);
        end else if (pu) begin
            if (m_stk.size() == DEPTH) eset = 1'b1;
            else m_stk.push_back(old_cc);
            if (lc) m_cc = ref_class(b);
        end else if (po) begin
            if (m_stk.size() == 0) begin
                eset = 1'b1;
                if (lc) m_cc = ref_class(b);
            end else begin
                m_cc = m_stk.pop_back();
            end
        end else if (lc) begin
            m_cc = ref_class(b);
        end
        if (eset) m_err = 1'b1;
        else if (cl) m_err = 1'b0;
        e.cc = m_cc; e.ben = m_ben; e.level = m_stk.size(); e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic idle();
        step('0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every edge that has a pending expectation is compared just after it.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("nzp", {29'd0, n, z, p}, {29'd0, e.cc});
            check("ben", {31'd0, ben}, {31'd0, e.ben});
            check("stk_level", {{(32-LW){1'b0}}, stk_level}, e.level);
            check("stk_err", {31'd0, stk_err}, {31'd0, e.err});
            check("stk_empty", {31'd0, stk_empty}, {31'd0, e.level == 0});
            check("stk_full", {31'd0, stk_full}, {31'd0, e.level == DEPTH});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] rb;
        int               wait_cyc;
        model_reset();
        #12;
        check("rst_nzp", {29'd0, n, z, p}, 32'h2);
        check("rst_ben", {31'd0, ben}, 32'h0);
        check("rst_level", {{(32-LW){1'b0}}, stk_level}, 32'h0);
        check("rst_err", {31'd0, stk_err}, 32'h0);
        check("rst_empty", {31'd0, stk_empty}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Classification
        step(16'h0000, 1, 0, 3'b000, 0, 0, 0);
        step(16'h8001, 1, 0, 3'b000, 0, 0, 0);
        step(16'h7FFF, 1, 0, 3'b000, 0, 0, 0);

        // Branch enable, including same-edge CC load
        step(16'h8000, 1, 0, 3'b000, 0, 0, 0);
        step(16'h0000, 0, 1, 3'b011, 0, 0, 0);
        step(16'h0000, 0, 1, 3'b100, 0, 0, 0);
        step(16'h0000, 1, 1, 3'b100, 0, 0, 0);

        // Fill the stack with 001,010,100,001, overflow, then unwind
        step(16'h0001, 1, 0, 3'b000, 0, 0, 0);
        step(16'h0000, 1, 0, 3'b000, 1, 0, 0);
        step(16'h8000, 1, 0, 3'b000, 1, 0, 0);
        step(16'h0001, 1, 0, 3'b000, 1, 0, 0);
        step(16'h0000, 0, 0, 3'b000, 1, 0, 0);
        step(16'h0000, 0, 0, 3'b000, 1, 0, 0);
        step(16'h0000, 0, 0, 3'b000, 0, 0, 1);
        repeat (4) step(16'h0000, 0, 0, 3'b000, 0, 1, 0);

        // Underflow still honours LD_CC, then clear
        step(16'hFFFF, 1, 0, 3'b000, 0, 1, 0);
        step(16'h0000, 0, 0, 3'b000, 0, 0, 1);

        // Collision at level 1, then pop beats LD_CC
        step(16'h0001, 1, 0, 3'b000, 0, 0, 0);
        step(16'h0000, 0, 0, 3'b000, 1, 0, 0);
        step(16'h8000, 1, 0, 3'b000, 1, 1, 0);
        step(16'h0000, 1, 0, 3'b000, 0, 1, 0);
        step(16'h0000, 0, 0, 3'b000, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rb = 16'h0000;
                1: rb = 16'h8000;
                2: rb = 16'h7FFF;
                default: rb = WIDTH'($urandom);
            endcase
            step(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0));
        end

        // Async reset at level 3, mid-cycle
        step(16'h0001, 1, 0, 3'b000, 0, 0, 1);
        step(16'h0000, 0, 0, 3'b000, 0, 0, 0);
        while (m_stk.size() > 0) step(16'h0000, 0, 0, 3'b000, 0, 1, 0);
        step(16'h8000, 1, 0, 3'b000, 1, 0, 1);
        step(16'h0000, 0, 0, 3'b000, 1, 0, 0);
        step(16'h0000, 0, 1, 3'b111, 1, 0, 0);
        idle();
        @(posedge clk);
        #2;
        check("pre_rst_level", {{(32-LW){1'b0}}, stk_level}, 32'h3);
        check("pre_rst_ben", {31'd0, ben}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_level", {{(32-LW){1'b0}}, stk_level}, 32'h0);
        check("arst_nzp", {29'd0, n, z, p}, 32'h2);
        check("arst_ben", {31'd0, ben}, 32'h0);
        check("arst_empty", {31'd0, stk_empty}, 32'h1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(16'h0000, 0, 0, 3'b000, 0, 1, 0);
        step(16'h8001, 1, 0, 3'b000, 0, 0, 1);
        idle();

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
